// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for a 5-stage RV32IM core (IF/ID/EX/MEM/WB).
// Branches and jalr resolve in ID, so operands that are still in flight in EX
// or MEM must be waited on. Multi-cycle mul/div ops hold EX until they finish.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   reset               synchronous, active-low reset
//   rs1/rs2_address_id_i, rs1/rs2_used_id_i   source operands of the ID instruction
//   branch_id_i         ID instruction is a branch/jalr resolved in ID
//   branch_taken_id_i   that branch resolved taken
//   rd_address_ex_i, reg_write_ex_i, mem_read_ex_i   EX destination / write / load
//   rd_address_mem_i, mem_read_mem_i                 MEM destination / load
//   muldiv_start_ex_i   multi-cycle M-extension op entering EX
//   muldiv_done_i       multi-cycle result valid
//   pc_en_o, if_id_en_o, id_ex_en_o                  stage advance enables
//   if_id_flush_o, id_ex_flush_o, ex_mem_flush_o     bubble inserts
//   stall_cnt_o         saturating stall-cycle counter (HAZARD_PERF_CNT_EN only)
//
// Configuration
//   HAZARD_PERF_CNT_EN  when defined, adds the stall_cnt_o port and counter.
//
// FSM: RUN (normal hazard evaluation), BUBBLE (extra load-to-branch bubbles),
// MULDIV (EX held by a multi-cycle op). Outputs are combinational from state
// and inputs because a hazard must stall in the same cycle it is seen.
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_address_id_i,
  input  logic [4:0] rs2_address_id_i,
  input  logic       rs1_used_id_i,
  input  logic       rs2_used_id_i,
  input  logic       branch_id_i,
  input  logic       branch_taken_id_i,
  input  logic [4:0] rd_address_ex_i,
  input  logic       reg_write_ex_i,
  input  logic       mem_read_ex_i,
  input  logic [4:0] rd_address_mem_i,
  input  logic       mem_read_mem_i,
  input  logic       muldiv_start_ex_i,
  input  logic       muldiv_done_i,
  output logic       pc_en_o,
  output logic       if_id_en_o,
  output logic       id_ex_en_o,
  output logic       if_id_flush_o,
  output logic       id_ex_flush_o,
  output logic       ex_mem_flush_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  // Elaboration-time sanity check on the counter width.
  if (STALL_CNT_W == 0) begin : g_bad_width
    $error("hazard_unit: STALL_CNT_W must be at least 1");
  end

  localparam int unsigned BUBBLE_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_MULDIV = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [BUBBLE_CNT_W-1:0] bubble_dec_s;

  logic dep_ex_s;
  logic dep_mem_s;
  logic load_use_s;
  logic branch_alu_ex_s;
  logic branch_load_ex_s;
  logic branch_load_mem_s;
  logic run_hazard_s;
  logic stall_s;
  logic freeze_s;

  // Operand match of the ID instruction against the EX and MEM destinations;
  // x0 never creates a dependency.
  always_comb begin
    dep_ex_s  = (rd_address_ex_i != 5'd0) &&
                ((rs1_used_id_i && (rs1_address_id_i == rd_address_ex_i)) ||
                 (rs2_used_id_i && (rs2_address_id_i == rd_address_ex_i)));
    dep_mem_s = (rd_address_mem_i != 5'd0) &&
                ((rs1_used_id_i && (rs1_address_id_i == rd_address_mem_i)) ||
                 (rs2_used_id_i && (rs2_address_id_i == rd_address_mem_i)));
  end

  // Hazard classes evaluated while in RUN. ALU results are forwarded to EX
  // but not to the ID comparator, hence the branch-on-ALU stall.
  always_comb begin
    load_use_s         = mem_read_ex_i && dep_ex_s;
    branch_alu_ex_s    = branch_id_i && reg_write_ex_i && !mem_read_ex_i && dep_ex_s;
    branch_load_ex_s   = branch_id_i && mem_read_ex_i && dep_ex_s;
    branch_load_mem_s  = branch_id_i && mem_read_mem_i && dep_mem_s;
    run_hazard_s       = load_use_s || branch_alu_ex_s ||
                         branch_load_ex_s || branch_load_mem_s;
  end

  assign bubble_dec_s = bubble_cnt_q - {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};

  // Next-state logic and stall/freeze classification for the current cycle.
  always_comb begin
    state_d      = state_q;
    bubble_cnt_d = bubble_cnt_q;
    stall_s      = 1'b0;
    freeze_s     = 1'b0;
    if (!reset) begin
      state_d      = ST_RUN;
      bubble_cnt_d = {BUBBLE_CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_RUN: begin
          stall_s = run_hazard_s;
          if (muldiv_start_ex_i) begin
            // The start cycle advances normally; the hold begins next cycle.
            state_d      = ST_MULDIV;
            bubble_cnt_d = {BUBBLE_CNT_W{1'b0}};
          end else if (branch_load_ex_s) begin
            // Load data only exists after MEM, so a branch needs a second
            // bubble; a plain load-use in the same cycle is subsumed.
            state_d      = ST_BUBBLE;
            bubble_cnt_d = {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_d      = ST_RUN;
            bubble_cnt_d = {BUBBLE_CNT_W{1'b0}};
          end
        end
        ST_BUBBLE: begin
          stall_s      = 1'b1;
          bubble_cnt_d = bubble_dec_s;
          if (muldiv_start_ex_i) begin
            state_d      = ST_MULDIV;
            bubble_cnt_d = {BUBBLE_CNT_W{1'b0}};
          end else if (bubble_dec_s == {BUBBLE_CNT_W{1'b0}}) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_BUBBLE;
          end
        end
        ST_MULDIV: begin
          // Hazards seen here are not acted on; RUN re-evaluates them after
          // the done cycle.
          if (muldiv_done_i) begin
            state_d = ST_RUN;
          end else begin
            freeze_s = 1'b1;
            state_d  = ST_MULDIV;
          end
        end
        default: begin
          state_d      = ST_RUN;
          bubble_cnt_d = {BUBBLE_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output decode: reset forces a full pipeline squash, the mul/div hold
  // freezes everything up to EX and bubbles MEM, a stall holds IF/ID and
  // bubbles ID/EX. A taken branch may only flush IF/ID when nothing stalls.
  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    if (!reset) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
    end else if (freeze_s) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_flush_o = 1'b1;
    end else if (stall_s) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end else begin
      if_id_flush_o = branch_taken_id_i;
    end
  end

  // FSM state and bubble counter; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      bubble_cnt_q <= {BUBBLE_CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which the PC was held outside reset.
  always_comb begin
    if (!pc_en_o && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  // Expected output vector layout:
  // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush}
  localparam logic [5:0] E_RST   = 6'b000_111;
  localparam logic [5:0] E_RUN   = 6'b111_000;
  localparam logic [5:0] E_TAKEN = 6'b111_100;
  localparam logic [5:0] E_STALL = 6'b001_010;
  localparam logic [5:0] E_MD    = 6'b000_001;

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned TB_CNT_W = 4;
`endif

  logic       clk;
  logic       reset;
  logic [4:0] rs1_address_id_i, rs2_address_id_i;
  logic       rs1_used_id_i, rs2_used_id_i;
  logic       branch_id_i, branch_taken_id_i;
  logic [4:0] rd_address_ex_i;
  logic       reg_write_ex_i, mem_read_ex_i;
  logic [4:0] rd_address_mem_i;
  logic       mem_read_mem_i;
  logic       muldiv_start_ex_i, muldiv_done_i;
  logic       pc_en_o, if_id_en_o, id_ex_en_o;
  logic       if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt_o;
`endif

`ifdef HAZARD_PERF_CNT_EN
  hazard_unit #(.STALL_CNT_W(TB_CNT_W)) dut (
`else
  hazard_unit dut (
`endif
    .clk               (clk),
    .reset             (reset),
    .rs1_address_id_i  (rs1_address_id_i),
    .rs2_address_id_i  (rs2_address_id_i),
    .rs1_used_id_i     (rs1_used_id_i),
    .rs2_used_id_i     (rs2_used_id_i),
    .branch_id_i       (branch_id_i),
    .branch_taken_id_i (branch_taken_id_i),
    .rd_address_ex_i   (rd_address_ex_i),
    .reg_write_ex_i    (reg_write_ex_i),
    .mem_read_ex_i     (mem_read_ex_i),
    .rd_address_mem_i  (rd_address_mem_i),
    .mem_read_mem_i    (mem_read_mem_i),
    .muldiv_start_ex_i (muldiv_start_ex_i),
    .muldiv_done_i     (muldiv_done_i),
    .pc_en_o           (pc_en_o),
    .if_id_en_o        (if_id_en_o),
    .id_ex_en_o        (id_ex_en_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_flush_o     (id_ex_flush_o),
    .ex_mem_flush_o    (ex_mem_flush_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o       (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [5:0] exp;
    logic       rst;
  } item_t;

  item_t sb_q[$];
  int    total_cnt = 0;
  int    pass_cnt  = 0;

  // Monitor: each cycle's outputs are compared mid-cycle against the queued
  // expectation for that cycle.
  initial begin : monitor
    item_t       e;
    logic [5:0]  act;
`ifdef HAZARD_PERF_CNT_EN
    logic [TB_CNT_W-1:0] exp_cnt;
    exp_cnt = '0;
`endif
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {pc_en_o, if_id_en_o, id_ex_en_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o};
        total_cnt++;
        if (act === e.exp) pass_cnt++;
        else $display("FAIL %s: outputs got %b expected %b", e.nm, act, e.exp);
`ifdef HAZARD_PERF_CNT_EN
        total_cnt++;
        if (stall_cnt_o === exp_cnt) pass_cnt++;
        else $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, stall_cnt_o, exp_cnt);
        if (!e.rst) exp_cnt = '0;
        else if (!e.exp[5] && exp_cnt != {TB_CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
`endif
      end
    end
  end

  task automatic clr();
    rs1_address_id_i  = 5'd0;
    rs2_address_id_i  = 5'd0;
    rs1_used_id_i     = 1'b0;
    rs2_used_id_i     = 1'b0;
    branch_id_i       = 1'b0;
    branch_taken_id_i = 1'b0;
    rd_address_ex_i   = 5'd0;
    reg_write_ex_i    = 1'b0;
    mem_read_ex_i     = 1'b0;
    rd_address_mem_i  = 5'd0;
    mem_read_mem_i    = 1'b0;
    muldiv_start_ex_i = 1'b0;
    muldiv_done_i     = 1'b0;
  endtask

  // Queue the expectation for the inputs currently driven, then advance.
  task automatic cyc(input string nm, input logic [5:0] exp);
    item_t it;
    it.nm  = nm;
    it.exp = exp;
    it.rst = reset;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // lw xRD in EX
  task automatic load_ex(input logic [4:0] rd);
    rd_address_ex_i = rd;
    reg_write_ex_i  = 1'b1;
    mem_read_ex_i   = 1'b1;
  endtask

  initial begin : stim
    clr();
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset_0", E_RST);
    cyc("reset_1", E_RST);
    reset = 1'b1;
    cyc("idle", E_RUN);

    // lw x5 ; add uses x5 -> one bubble
    load_ex(5'd5); rs1_address_id_i = 5'd5; rs1_used_id_i = 1'b1;
    cyc("load_use_rs1", E_STALL);
    clr(); rd_address_mem_i = 5'd5; mem_read_mem_i = 1'b1;
    rs1_address_id_i = 5'd5; rs1_used_id_i = 1'b1;
    cyc("load_use_after", E_RUN);

    // rs1 matches but unused; rs2 used and different -> no stall
    clr(); load_ex(5'd5); rs1_address_id_i = 5'd5; rs2_address_id_i = 5'd6; rs2_used_id_i = 1'b1;
    cyc("load_unused_match", E_RUN);
    rs2_address_id_i = 5'd5;
    cyc("load_use_rs2", E_STALL);

    // lw x5 ; beq x5,x0 taken -> two bubbles, then taken flush
    clr(); load_ex(5'd5); rs1_address_id_i = 5'd5; rs1_used_id_i = 1'b1;
    rs2_used_id_i = 1'b1; branch_id_i = 1'b1; branch_taken_id_i = 1'b1;
    cyc("br_load_stall1", E_STALL);
    rd_address_ex_i = 5'd0; reg_write_ex_i = 1'b0; mem_read_ex_i = 1'b0;
    rd_address_mem_i = 5'd5; mem_read_mem_i = 1'b1;
    cyc("br_load_stall2", E_STALL);
    rd_address_mem_i = 5'd0; mem_read_mem_i = 1'b0;
    cyc("br_load_resolve", E_TAKEN);

    // add x7 ; jalr x7 -> exactly one bubble
    clr(); rd_address_ex_i = 5'd7; reg_write_ex_i = 1'b1;
    rs1_address_id_i = 5'd7; rs1_used_id_i = 1'b1; branch_id_i = 1'b1; branch_taken_id_i = 1'b1;
    cyc("br_alu_stall", E_STALL);
    rd_address_ex_i = 5'd0; reg_write_ex_i = 1'b0; rd_address_mem_i = 5'd7;
    cyc("br_alu_resolve", E_TAKEN);

    // ALU dependency on a non-branch is forwarded -> no stall
    clr(); rd_address_ex_i = 5'd7; reg_write_ex_i = 1'b1;
    rs2_address_id_i = 5'd7; rs2_used_id_i = 1'b1;
    cyc("alu_forward", E_RUN);

    // lw x0 with rs1 = x0 -> no stall
    clr(); load_ex(5'd0); rs1_used_id_i = 1'b1; branch_id_i = 1'b1;
    cyc("load_x0", E_RUN);

    // Branch on a load now in MEM -> one bubble
    clr(); rd_address_mem_i = 5'd3; mem_read_mem_i = 1'b1;
    rs2_address_id_i = 5'd3; rs2_used_id_i = 1'b1; branch_id_i = 1'b1;
    cyc("br_load_mem", E_STALL);
    mem_read_mem_i = 1'b0;
    cyc("br_load_mem_after", E_RUN);

    // div: start cycle advances, 33 held cycles, done cycle releases
    clr(); muldiv_start_ex_i = 1'b1;
    cyc("muldiv_start", E_RUN);
    clr();
    for (int i = 0; i < 33; i++) begin
      if (i >= 30) begin
        // A pending load-use and taken branch must not leak through the hold.
        load_ex(5'd9); rs1_address_id_i = 5'd9; rs1_used_id_i = 1'b1; branch_taken_id_i = 1'b1;
      end
      cyc("muldiv_busy", E_MD);
    end
    clr(); muldiv_done_i = 1'b1;
    cyc("muldiv_done", E_RUN);
    clr(); load_ex(5'd9); rs1_address_id_i = 5'd9; rs1_used_id_i = 1'b1;
    cyc("post_muldiv_load_use", E_STALL);
    clr();
    cyc("post_muldiv_idle", E_RUN);

    // Reset in the middle of a mul/div hold
    muldiv_start_ex_i = 1'b1;
    cyc("muldiv2_start", E_RUN);
    clr();
    for (int i = 0; i < 3; i++) cyc("muldiv2_busy", E_MD);
    reset = 1'b0;
    cyc("muldiv2_reset", E_RST);
    reset = 1'b1; muldiv_done_i = 1'b1;
    cyc("muldiv2_after_reset", E_RUN);
    clr();
    cyc("muldiv2_idle", E_RUN);

    // Reset while in BUBBLE
    load_ex(5'd4); rs1_address_id_i = 5'd4; rs1_used_id_i = 1'b1; branch_id_i = 1'b1;
    cyc("bubble_enter", E_STALL);
    clr(); reset = 1'b0;
    cyc("bubble_reset", E_RST);
    reset = 1'b1;
    cyc("bubble_after_reset", E_RUN);

`ifdef HAZARD_PERF_CNT_EN
    // 20 consecutive held cycles on a 4-bit counter must saturate at 15
    muldiv_start_ex_i = 1'b1;
    cyc("sat_start", E_RUN);
    clr();
    for (int i = 0; i < 20; i++) cyc("sat_busy", E_MD);
    muldiv_done_i = 1'b1;
    cyc("sat_done", E_RUN);
    clr();
    @(negedge clk);
    total_cnt++;
    if (stall_cnt_o === 4'd15) pass_cnt++;
    else $display("FAIL stall_cnt_saturated: got %0d expected 15", stall_cnt_o);
`endif

    @(negedge clk);
    #1;
    total_cnt++;
    if (sb_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
